// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//   Two-stage branch resolution pipeline with valid/ready handshakes on both
//   sides. S1 registers the incoming branch and evaluates direction, next PC
//   and mispredict. S2 registers that result for the consumer. A mispredicted
//   branch raises a one-cycle fetch redirect as it moves from S1 to S2.
//   Saturating performance counters track resolved branches and mispredicts.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   flush                        drop every in-flight branch, no count/redirect
//   in_valid / in_ready          upstream handshake
//   in_op, in_lhs, in_rhs        compare op and rs1/rs2 operand values
//   in_pc, in_imm, in_pred_taken branch PC, sign-extended B-imm, prediction
//   out_valid / out_ready        downstream handshake
//   out_taken, out_next_pc       resolved direction and next PC
//   out_mispredict               resolved direction differs from prediction
//   redirect_valid, redirect_pc  one-cycle fetch redirect and its target
//   cnt_branches, cnt_mispredicts saturating performance counters
// -----------------------------------------------------------------------------
module branch_resolve (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_op,
   input  logic [31:0] in_lhs,
   input  logic [31:0] in_rhs,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_imm,
   input  logic        in_pred_taken,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_taken,
   output logic [31:0] out_next_pc,
   output logic        out_mispredict,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic [31:0] cnt_branches,
   output logic [31:0] cnt_mispredicts
);

   localparam logic [2:0] COM_OP_EQ  = 3'b000;
   localparam logic [2:0] COM_OP_NE  = 3'b001;
   localparam logic [2:0] COM_OP_LT  = 3'b100;
   localparam logic [2:0] COM_OP_GE  = 3'b101;
   localparam logic [2:0] COM_OP_LTU = 3'b110;
   localparam logic [2:0] COM_OP_GEU = 3'b111;

   // S1: captured branch fields
   logic        s1_valid_q, s1_valid_d;
   logic [2:0]  s1_op_q, s1_op_d;
   logic [31:0] s1_lhs_q, s1_lhs_d;
   logic [31:0] s1_rhs_q, s1_rhs_d;
   logic [31:0] s1_pc_q, s1_pc_d;
   logic [31:0] s1_imm_q, s1_imm_d;
   logic        s1_pred_q, s1_pred_d;

   // S2: resolved result
   logic        s2_valid_q, s2_valid_d;
   logic        s2_taken_q, s2_taken_d;
   logic [31:0] s2_next_pc_q, s2_next_pc_d;
   logic        s2_mispredict_q, s2_mispredict_d;

   logic        redirect_valid_q, redirect_valid_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic [31:0] cnt_branches_q, cnt_branches_d;
   logic [31:0] cnt_mispredicts_q, cnt_mispredicts_d;

   logic        s1_advance;
   logic        accept;
   logic        s1_taken;
   logic        s1_mispredict;
   logic [31:0] s1_sum;
   logic [31:0] s1_next_pc;

   assign s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
   // reset_n gates in_ready so nothing is offered as accepted while in reset.
   assign in_ready   = reset_n && !flush && (!s1_valid_q || s1_advance);
   assign accept     = in_valid && in_ready;

   // Direction evaluation; the two unused encodings fall through to not-taken.
   // NOTE: every signal assigned in an always_comb gets a default first so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      s1_taken = 1'b0;
      case (s1_op_q)
         COM_OP_EQ:  s1_taken = (s1_lhs_q == s1_rhs_q);
         COM_OP_NE:  s1_taken = (s1_lhs_q != s1_rhs_q);
         COM_OP_LT:  s1_taken = ($signed(s1_lhs_q) <  $signed(s1_rhs_q));
         COM_OP_GE:  s1_taken = ($signed(s1_lhs_q) >= $signed(s1_rhs_q));
         COM_OP_LTU: s1_taken = (s1_lhs_q <  s1_rhs_q);
         COM_OP_GEU: s1_taken = (s1_lhs_q >= s1_rhs_q);
         default:    s1_taken = 1'b0;
      endcase
   end

   // 32-bit adds wrap naturally; the target's bit 0 is forced clear.
   assign s1_sum        = s1_pc_q + s1_imm_q;
   assign s1_next_pc    = s1_taken ? {s1_sum[31:1], 1'b0} : (s1_pc_q + 32'd4);
   assign s1_mispredict = s1_taken ^ s1_pred_q;

   always_comb begin
      s1_valid_d        = s1_valid_q;
      s1_op_d           = s1_op_q;
      s1_lhs_d          = s1_lhs_q;
      s1_rhs_d          = s1_rhs_q;
      s1_pc_d           = s1_pc_q;
      s1_imm_d          = s1_imm_q;
      s1_pred_d         = s1_pred_q;
      s2_valid_d        = s2_valid_q;
      s2_taken_d        = s2_taken_q;
      s2_next_pc_d      = s2_next_pc_q;
      s2_mispredict_d   = s2_mispredict_q;
      redirect_valid_d  = 1'b0;
      redirect_pc_d     = redirect_pc_q;
      cnt_branches_d    = cnt_branches_q;
      cnt_mispredicts_d = cnt_mispredicts_q;

      // S1: flush wins; accept refills even while the old entry advances.
      if (flush) begin
         s1_valid_d = 1'b0;
      end else if (accept) begin
         s1_valid_d = 1'b1;
         s1_op_d    = in_op;
         s1_lhs_d   = in_lhs;
         s1_rhs_d   = in_rhs;
         s1_pc_d    = in_pc;
         s1_imm_d   = in_imm;
         s1_pred_d  = in_pred_taken;
      end else if (s1_advance) begin
         s1_valid_d = 1'b0;
      end

      // S2: load on advance, drain on pop, otherwise hold (stall-stable).
      if (flush) begin
         s2_valid_d = 1'b0;
      end else if (s1_advance) begin
         s2_valid_d      = 1'b1;
         s2_taken_d      = s1_taken;
         s2_next_pc_d    = s1_next_pc;
         s2_mispredict_d = s1_mispredict;
      end else if (s2_valid_q && out_ready) begin
         s2_valid_d = 1'b0;
      end

      // Redirect and counting tie to the S1->S2 move, so a branch stalled in
      // S2 never pulses twice and a flushed branch never pulses at all.
      if (!flush && s1_advance) begin
         if (s1_mispredict) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = s1_next_pc;
         end
         if (cnt_branches_q != 32'hFFFF_FFFF) begin
            cnt_branches_d = cnt_branches_q + 32'd1;
         end
         if (s1_mispredict && (cnt_mispredicts_q != 32'hFFFF_FFFF)) begin
            cnt_mispredicts_d = cnt_mispredicts_q + 32'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid_q        <= 1'b0;
         s1_op_q           <= '0;
         s1_lhs_q          <= '0;
         s1_rhs_q          <= '0;
         s1_pc_q           <= '0;
         s1_imm_q          <= '0;
         s1_pred_q         <= 1'b0;
         s2_valid_q        <= 1'b0;
         s2_taken_q        <= 1'b0;
         s2_next_pc_q      <= '0;
         s2_mispredict_q   <= 1'b0;
         redirect_valid_q  <= 1'b0;
         redirect_pc_q     <= '0;
         cnt_branches_q    <= '0;
         cnt_mispredicts_q <= '0;
      end else begin
         s1_valid_q        <= s1_valid_d;
         s1_op_q           <= s1_op_d;
         s1_lhs_q          <= s1_lhs_d;
         s1_rhs_q          <= s1_rhs_d;
         s1_pc_q           <= s1_pc_d;
         s1_imm_q          <= s1_imm_d;
         s1_pred_q         <= s1_pred_d;
         s2_valid_q        <= s2_valid_d;
         s2_taken_q        <= s2_taken_d;
         s2_next_pc_q      <= s2_next_pc_d;
         s2_mispredict_q   <= s2_mispredict_d;
         redirect_valid_q  <= redirect_valid_d;
         redirect_pc_q     <= redirect_pc_d;
         cnt_branches_q    <= cnt_branches_d;
         cnt_mispredicts_q <= cnt_mispredicts_d;
      end
   end

   assign out_valid       = s2_valid_q;
   assign out_taken       = s2_taken_q;
   assign out_next_pc     = s2_next_pc_q;
   assign out_mispredict  = s2_mispredict_q;
   assign redirect_valid  = redirect_valid_q;
   assign redirect_pc     = redirect_pc_q;
   assign cnt_branches    = cnt_branches_q;
   assign cnt_mispredicts = cnt_mispredicts_q;

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//   Directed bench for branch_resolve. Inputs change and outputs are sampled
//   1-2 time units after the rising edge; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

   localparam logic [2:0] OP_EQ  = 3'b000;
   localparam logic [2:0] OP_NE  = 3'b001;
   localparam logic [2:0] OP_RSV = 3'b010;
   localparam logic [2:0] OP_LT  = 3'b100;
   localparam logic [2:0] OP_GE  = 3'b101;
   localparam logic [2:0] OP_LTU = 3'b110;
   localparam logic [2:0] OP_GEU = 3'b111;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [31:0] in_lhs;
   logic [31:0] in_rhs;
   logic [31:0] in_pc;
   logic [31:0] in_imm;
   logic        in_pred_taken;
   logic        out_valid;
   logic        out_ready;
   logic        out_taken;
   logic [31:0] out_next_pc;
   logic        out_mispredict;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] cnt_branches;
   logic [31:0] cnt_mispredicts;

   int n_cmp = 0;
   int n_err = 0;

   branch_resolve dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .flush           (flush),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_op           (in_op),
      .in_lhs          (in_lhs),
      .in_rhs          (in_rhs),
      .in_pc           (in_pc),
      .in_imm          (in_imm),
      .in_pred_taken   (in_pred_taken),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_taken       (out_taken),
      .out_next_pc     (out_next_pc),
      .out_mispredict  (out_mispredict),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .cnt_branches    (cnt_branches),
      .cnt_mispredicts (cnt_mispredicts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [31:0] lhs, input logic [31:0] rhs,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred);
      in_valid      = 1'b1;
      in_op         = op;
      in_lhs        = lhs;
      in_rhs        = rhs;
      in_pc         = pc;
      in_imm        = imm;
      in_pred_taken = pred;
   endtask

   task automatic idle_in();
      in_valid = 1'b0;
   endtask

   initial begin
      reset_n       = 1'b0;
      flush         = 1'b0;
      in_valid      = 1'b0;
      in_op         = '0;
      in_lhs        = '0;
      in_rhs        = '0;
      in_pc         = '0;
      in_imm        = '0;
      in_pred_taken = 1'b0;
      out_ready     = 1'b1;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_in_ready",    in_ready,        0);
      check("rst_out_valid",   out_valid,       0);
      check("rst_out_taken",   out_taken,       0);
      check("rst_out_misp",    out_mispredict,  0);
      check("rst_out_next_pc", out_next_pc,     0);
      check("rst_redir_valid", redirect_valid,  0);
      check("rst_redir_pc",    redirect_pc,     0);
      check("rst_cnt_br",      cnt_branches,    0);
      check("rst_cnt_mis",     cnt_mispredicts, 0);
      reset_n = 1'b1;
      #1;
      check("rel_in_ready", in_ready, 1);

      // ---------------- BEQ taken, correctly predicted ----------------
      drive(OP_EQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
      #1;
      check("beq_in_ready", in_ready, 1);
      tick();
      idle_in();
      check("beq_lat1_valid", out_valid, 0);
      tick();
      check("beq_valid",   out_valid,      1);
      check("beq_taken",   out_taken,      1);
      check("beq_next_pc", out_next_pc,    32'h120);
      check("beq_misp",    out_mispredict, 0);
      check("beq_redir",   redirect_valid, 0);
      check("beq_cnt_br",  cnt_branches,   1);
      tick();
      check("beq_drain", out_valid, 0);

      // ---------------- BLT signed mispredict, then BLTU ----------------
      drive(OP_LT, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 1'b0);
      tick();
      idle_in();
      check("blt_redir_early", redirect_valid, 0);
      tick();
      check("blt_valid",     out_valid,       1);
      check("blt_taken",     out_taken,       1);
      check("blt_next_pc",   out_next_pc,     32'h240);
      check("blt_misp",      out_mispredict,  1);
      check("blt_redir",     redirect_valid,  1);
      check("blt_redir_pc",  redirect_pc,     32'h240);
      check("blt_cnt_mis",   cnt_mispredicts, 1);
      check("blt_cnt_br",    cnt_branches,    2);
      drive(OP_LTU, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1'b0);
      tick();
      idle_in();
      check("blt_redir_pulse", redirect_valid, 0);
      check("blt_drain",       out_valid,      0);
      tick();
      check("bltu_valid",   out_valid,       1);
      check("bltu_taken",   out_taken,       0);
      check("bltu_next_pc", out_next_pc,     32'h304);
      check("bltu_misp",    out_mispredict,  0);
      check("bltu_redir",   redirect_valid,  0);
      check("bltu_cnt_br",  cnt_branches,    3);
      check("bltu_cnt_mis", cnt_mispredicts, 1);
      tick();
      check("bltu_drain", out_valid, 0);

      // ---------------- back-to-back with downstream stall ----------------
      out_ready = 1'b0;
      drive(OP_NE, 32'd1, 32'd2, 32'h1000, 32'h10, 1'b1);     // A: taken -> 0x1010
      #1;
      check("bb_a_ready", in_ready, 1);
      tick();
      drive(OP_GE, 32'd3, 32'd3, 32'h2000, 32'h20, 1'b1);     // B: taken -> 0x2020
      #1;
      check("bb_b_ready", in_ready, 1);
      tick();
      drive(OP_GEU, 32'd0, 32'd1, 32'h3000, 32'h30, 1'b0);    // C: not taken -> 0x3004
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bb_stall_ready", in_ready,    0);
         check("bb_stall_valid", out_valid,   1);
         check("bb_stall_pc",    out_next_pc, 32'h1010);
         check("bb_stall_taken", out_taken,   1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("bb_c_ready", in_ready,    1);
      check("bb_out_a",   out_next_pc, 32'h1010);
      tick();
      drive(OP_EQ, 32'd7, 32'd8, 32'h4000, 32'h40, 1'b0);     // D: not taken -> 0x4004
      #1;
      check("bb_d_ready", in_ready,    1);
      check("bb_out_b",   out_next_pc, 32'h2020);
      check("bb_b_taken", out_taken,   1);
      tick();
      idle_in();
      check("bb_out_c",   out_next_pc, 32'h3004);
      check("bb_c_taken", out_taken,   0);
      tick();
      check("bb_out_d",    out_next_pc,  32'h4004);
      check("bb_d_valid",  out_valid,    1);
      check("bb_cnt_br",   cnt_branches, 7);
      tick();
      check("bb_drain", out_valid, 0);

      // ---------------- wraparound and reserved op, full throughput ----------------
      drive(OP_EQ, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1'b1);     // X: taken -> 0x4
      tick();
      drive(OP_NE, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8, 1'b0);     // Y: not taken -> 0x0
      tick();
      check("wrap_x_valid", out_valid,   1);
      check("wrap_x_taken", out_taken,   1);
      check("wrap_x_pc",    out_next_pc, 32'h0000_0004);
      drive(OP_RSV, 32'd0, 32'd0, 32'h500, 32'h20, 1'b0);         // Z: not taken -> 0x504
      tick();
      check("wrap_y_taken", out_taken,   0);
      check("wrap_y_pc",    out_next_pc, 32'h0000_0000);
      drive(OP_EQ, 32'd1, 32'd1, 32'h100, 32'd7, 1'b1);           // W: taken -> 0x106
      tick();
      idle_in();
      check("rsv_taken", out_taken,   0);
      check("rsv_pc",    out_next_pc, 32'h504);
      tick();
      check("odd_taken", out_taken,   1);
      check("odd_pc",    out_next_pc, 32'h106);
      tick();
      check("tp_drain",   out_valid,       0);
      check("tp_cnt_br",  cnt_branches,    11);
      check("tp_cnt_mis", cnt_mispredicts, 1);

      // ---------------- flush with S1 and S2 full ----------------
      out_ready = 1'b0;
      drive(OP_NE, 32'd1, 32'd2, 32'h600, 32'h10, 1'b1);      // P: correct prediction
      tick();
      drive(OP_EQ, 32'd1, 32'd1, 32'h700, 32'h10, 1'b0);      // Q: mispredict
      tick();
      drive(OP_EQ, 32'd2, 32'd2, 32'h800, 32'h10, 1'b1);      // R: must be refused
      out_ready = 1'b1;
      flush     = 1'b1;
      #1;
      check("fl_in_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      idle_in();
      check("fl_out_valid", out_valid,       0);
      check("fl_redir",     redirect_valid,  0);
      check("fl_cnt_br",    cnt_branches,    12);
      check("fl_cnt_mis",   cnt_mispredicts, 1);
      #1;
      check("fl_ready_after", in_ready, 1);
      tick();
      check("fl_no_accept", out_valid, 0);

      // ---------------- mispredict counter saturation ----------------
      force dut.cnt_mispredicts_q = 32'hFFFF_FFFF;
      #1;
      release dut.cnt_mispredicts_q;
      #1;
      check("sat_preload", cnt_mispredicts, 32'hFFFF_FFFF);
      drive(OP_LT, 32'hFFFF_FFFF, 32'd1, 32'h900, 32'h20, 1'b0);
      tick();
      idle_in();
      tick();
      check("sat_redir",    redirect_valid,  1);
      check("sat_redir_pc", redirect_pc,     32'h920);
      check("sat_cnt_mis",  cnt_mispredicts, 32'hFFFF_FFFF);
      check("sat_cnt_br",   cnt_branches,    13);

      // ---------------- reset mid-stream ----------------
      drive(OP_LT, 32'hFFFF_FFFF, 32'd1, 32'hA00, 32'h10, 1'b0);
      tick();
      drive(OP_EQ, 32'd3, 32'd3, 32'hB00, 32'h10, 1'b1);
      reset_n = 1'b0;
      #1;
      check("mr_in_ready", in_ready, 0);
      tick();
      check("mr_out_valid", out_valid,       0);
      check("mr_redir",     redirect_valid,  0);
      check("mr_taken",     out_taken,       0);
      check("mr_misp",      out_mispredict,  0);
      check("mr_next_pc",   out_next_pc,     0);
      check("mr_redir_pc",  redirect_pc,     0);
      check("mr_cnt_br",    cnt_branches,    0);
      check("mr_cnt_mis",   cnt_mispredicts, 0);
      reset_n = 1'b1;
      idle_in();
      #1;
      check("mr_rel_ready", in_ready, 1);
      tick();
      check("mr_empty_valid", out_valid,      0);
      check("mr_empty_redir", redirect_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
